// File: rtl/usb_rx_phy_pkg.sv
// Shared types and defaults for the low-speed USB receive front end.
package usb_rx_phy_pkg;

  localparam int DEF_CLK_PER_BIT  = 16;
  localparam int DEF_SAMPLE_PHASE = 8;
  localparam int DEF_IDLE_BITS    = 8;

  // Decoded SYNC field, LSB first: seven zeros then the closing one (K K).
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

  typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SYNC, DATA, EOP} rx_state_t;

  // Low-speed line states: J = {dp,dm} 01, K = 10.
  function automatic line_state_t decode_line(input logic d_plus, input logic d_minus);
    case ({d_plus, d_minus})
      2'b01:   return J;
      2'b10:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_phy_if.sv
// Byte-stream interface from the receive PHY to the USB controller.
interface usb_rx_phy_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  modport master (output rx_data, rx_valid, rx_active, rx_error);
  modport slave  (input  rx_data, rx_valid, rx_active, rx_error);
endinterface

// File: rtl/usb_bit_dpll.sv
// Line synchroniser and bit-clock recovery: decodes the line state and
// emits a one-clk strobe in the middle of every bit cell.
module usb_bit_dpll
  import usb_rx_phy_pkg::*;
#(
  parameter int CLK_PER_BIT  = DEF_CLK_PER_BIT,
  parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dp,
  input  logic        dm,
  output line_state_t line_state,
  output logic        sample
);

  localparam int PHASE_W = $clog2(CLK_PER_BIT);

  logic [1:0]         meta_reg;
  logic [1:0]         sync_reg;
  line_state_t        prev_ls_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;
  logic               jk_edge;

  // Two-flop synchroniser for both lines, plus history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg    <= 2'b00;
      sync_reg    <= 2'b00;
      prev_ls_reg <= SE0;
      phase_reg   <= '0;
    end else begin
      meta_reg    <= {dp, dm};
      sync_reg    <= meta_reg;
      prev_ls_reg <= line_state;
      phase_reg   <= phase_next;
    end
  end

  assign line_state = decode_line(sync_reg[1], sync_reg[0]);

  // Phase counter free-runs per bit cell and realigns on every J<->K edge;
  // SE0/SE1 edges carry no timing information and are ignored.
  always_comb begin
    jk_edge = ((prev_ls_reg == J) && (line_state == K)) ||
              ((prev_ls_reg == K) && (line_state == J));
    if (jk_edge || (phase_reg == PHASE_W'(CLK_PER_BIT - 1))) begin
      phase_next = '0;
    end else begin
      phase_next = phase_reg + 1'b1;
    end
  end

  assign sample = (phase_reg == PHASE_W'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receiver: SYNC hunt, NRZI decode, bit unstuffing,
// byte assembly (LSB first) and EOP / error detection.
module usb_rx_phy
  import usb_rx_phy_pkg::*;
#(
  parameter int CLK_PER_BIT  = DEF_CLK_PER_BIT,
  parameter int SAMPLE_PHASE = DEF_SAMPLE_PHASE,
  parameter int IDLE_BITS    = DEF_IDLE_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         dp,
  input  logic         dm,
  usb_rx_phy_if.master rx
);

  localparam int IDLE_W = $clog2(IDLE_BITS);

  line_state_t line_state;
  logic        sample;

  usb_bit_dpll #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .SAMPLE_PHASE(SAMPLE_PHASE)
  ) u_dpll (
    .clk       (clk),
    .reset     (reset),
    .dp        (dp),
    .dm        (dm),
    .line_state(line_state),
    .sample    (sample)
  );

  rx_state_t         state_reg, state_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [2:0]        sync_cnt_reg, sync_cnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [2:0]        ones_reg, ones_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        data_reg, data_next;
  logic              prev_k_reg, prev_k_next;
  logic              valid_reg, valid_next;
  logic              active_reg, active_next;
  logic              error_reg, error_next;
  logic              is_jk;
  logic              bit_val;
  logic              fail;
  logic [7:0]        shifted;

  // State and datapath registers; outputs are registered straight from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= WAIT_IDLE;
      idle_cnt_reg <= '0;
      sync_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      ones_reg     <= '0;
      shift_reg    <= '0;
      data_reg     <= '0;
      prev_k_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      active_reg   <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      sync_cnt_reg <= sync_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      ones_reg     <= ones_next;
      shift_reg    <= shift_next;
      data_reg     <= data_next;
      prev_k_reg   <= prev_k_next;
      valid_reg    <= valid_next;
      active_reg   <= active_next;
      error_reg    <= error_next;
    end
  end

  // Receive FSM: everything advances only on the mid-bit sample strobe.
  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    sync_cnt_next = sync_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    ones_next     = ones_reg;
    shift_next    = shift_reg;
    data_next     = data_reg;
    prev_k_next   = prev_k_reg;
    valid_next    = 1'b0;
    active_next   = active_reg;
    error_next    = 1'b0;
    fail          = 1'b0;
    is_jk         = (line_state == J) || (line_state == K);
    // NRZI: no level change between samples decodes as a one.
    bit_val       = ((line_state == K) == prev_k_reg);
    shifted       = {bit_val, shift_reg[7:1]};

    if (sample) begin
      if (is_jk) begin
        prev_k_next = (line_state == K);
      end
      case (state_reg)
        WAIT_IDLE: begin
          if (line_state == J) begin
            if (idle_cnt_reg == IDLE_W'(IDLE_BITS - 1)) begin
              state_next    = IDLE;
              idle_cnt_next = '0;
            end else begin
              idle_cnt_next = idle_cnt_reg + 1'b1;
            end
          end else begin
            idle_cnt_next = '0;
          end
        end
        IDLE: begin
          // Only a genuine J->K change opens a SYNC; the first K is symbol 0.
          if ((line_state == K) && !prev_k_reg) begin
            state_next    = SYNC;
            sync_cnt_next = 3'd1;
          end
        end
        SYNC: begin
          if (line_state == SE1) begin
            fail = 1'b1;
          end else if (!is_jk || (bit_val != SYNC_PATTERN[sync_cnt_reg])) begin
            state_next = IDLE;
          end else if (sync_cnt_reg == 3'd7) begin
            state_next   = DATA;
            active_next  = 1'b1;
            bit_cnt_next = '0;
            ones_next    = '0;
          end else begin
            sync_cnt_next = sync_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (line_state == SE1) begin
            fail = 1'b1;
          end else if (line_state == SE0) begin
            if (bit_cnt_reg != 3'd0) begin
              fail = 1'b1;
            end else begin
              state_next = EOP;
            end
          end else if (ones_reg == 3'd6) begin
            // Stuffed bit: must be zero, and is dropped from the byte.
            if (bit_val) begin
              fail = 1'b1;
            end else begin
              ones_next = '0;
            end
          end else begin
            ones_next    = bit_val ? ones_reg + 1'b1 : 3'd0;
            shift_next   = shifted;
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) begin
              data_next  = shifted;
              valid_next = 1'b1;
            end
          end
        end
        EOP: begin
          if (line_state == J) begin
            active_next = 1'b0;
            state_next  = IDLE;
          end else if (line_state != SE0) begin
            fail = 1'b1;
          end
        end
        default: begin
          state_next = WAIT_IDLE;
        end
      endcase
    end

    if (fail) begin
      error_next    = 1'b1;
      active_next   = 1'b0;
      valid_next    = 1'b0;
      state_next    = WAIT_IDLE;
      idle_cnt_next = '0;
    end
  end

  assign rx.rx_data   = data_reg;
  assign rx.rx_valid  = valid_reg;
  assign rx.rx_active = active_reg;
  assign rx.rx_error  = error_reg;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Self-checking bench for usb_rx_phy: drives NRZI/stuffed line symbols and
// checks received bytes through a scoreboard queue.
`timescale 1ns/1ps
module tb_usb_rx_phy;

  localparam real BIT_NS = 672.0;  // 16 clk of 42 ns
  localparam logic [1:0] LS_J = 2'b01;
  localparam logic [1:0] LS_K = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dp = 1'b0;
  logic dm = 1'b1;

  usb_rx_phy_if rx_if();

  usb_rx_phy dut (
    .clk  (clk),
    .reset(reset),
    .dp   (dp),
    .dm   (dm),
    .rx   (rx_if)
  );

  always #21 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int rise_cnt = 0;
  int eop_idx = 0;
  int valid_cyc[$];
  logic [7:0] exp_q[$];
  logic [1:0] sym_q[$];
  bit bits_q[$];
  logic [7:0] mon_exp;
  logic active_prev = 1'b0;
  logic active_before_eop = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard monitor: pops one expected byte per rx_valid pulse.
  always @(negedge clk) begin
    if (rx_if.rx_valid === 1'b1) begin
      valid_cnt++;
      valid_cyc.push_back(cycle);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %h, none expected", rx_if.rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_if.rx_data !== mon_exp) begin
          errors++;
          $display("FAIL rx_data: got %h want %h", rx_if.rx_data, mon_exp);
        end else begin
          $display("rx byte %h at cycle %0d", rx_if.rx_data, cycle);
        end
      end
      checks++;
      if (rx_if.rx_error !== 1'b0 || rx_if.rx_active !== 1'b1) begin
        errors++;
        $display("FAIL valid_qualifiers: error=%b active=%b want error=0 active=1",
                 rx_if.rx_error, rx_if.rx_active);
      end
    end
    if (rx_if.rx_error === 1'b1) begin
      err_cnt++;
      $display("rx_error pulse at cycle %0d", cycle);
    end
    if (rx_if.rx_active === 1'b1 && active_prev !== 1'b1) rise_cnt++;
    active_prev = rx_if.rx_active;
  end

  task automatic drive(input logic [1:0] s, input real per);
    {dp, dm} = s;
    #(per);
  endtask

  task automatic idle(input int n, input real per);
    for (int i = 0; i < n; i++) drive(LS_J, per);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
  endtask

  // Encode bits_q into line symbols: SYNC, NRZI data (optionally stuffed), EOP.
  task automatic build(input bit stuff, input bit with_eop);
    logic [1:0] lvl;
    int ones;
    sym_q.delete();
    for (int i = 0; i < 6; i++) sym_q.push_back((i % 2 == 0) ? LS_K : LS_J);
    sym_q.push_back(LS_K);
    sym_q.push_back(LS_K);
    lvl = LS_K;
    ones = 0;
    foreach (bits_q[i]) begin
      if (bits_q[i] == 1'b0) begin
        lvl = (lvl == LS_J) ? LS_K : LS_J;
        ones = 0;
      end else begin
        ones++;
      end
      sym_q.push_back(lvl);
      if (stuff && ones == 6) begin
        lvl = (lvl == LS_J) ? LS_K : LS_J;
        ones = 0;
        sym_q.push_back(lvl);
      end
    end
    eop_idx = sym_q.size();
    if (with_eop) begin
      sym_q.push_back(LS_SE0);
      sym_q.push_back(LS_SE0);
      sym_q.push_back(LS_J);
    end
    bits_q.delete();
  endtask

  task automatic send(input real per, input int from, input int to);
    for (int i = from; i < to; i++) begin
      if (i == eop_idx) active_before_eop = rx_if.rx_active;
      drive(sym_q[i], per);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_if.rx_data); end
    checks++;
    if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_if.rx_valid); end
    checks++;
    if (rx_if.rx_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", rx_if.rx_active); end
    checks++;
    if (rx_if.rx_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", rx_if.rx_error); end
    reset = 1'b1;
    idle(10, BIT_NS);
  endtask

  task automatic test_setup_pid();
    int v0 = valid_cnt, e0 = err_cnt, r0 = rise_cnt;
    @(negedge clk);
    add_byte(8'h2D);
    build(1'b1, 1'b1);
    exp_q.push_back(8'h2D);
    send(BIT_NS, 0, sym_q.size());
    idle(4, BIT_NS);
    checks++;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL pid_valid_count: got %0d want 1", valid_cnt - v0); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL pid_error_count: got %0d want 0", err_cnt - e0); end
    checks++;
    if (rise_cnt - r0 != 1) begin errors++; $display("FAIL pid_active_rises: got %0d want 1", rise_cnt - r0); end
    checks++;
    if (active_before_eop !== 1'b1) begin errors++; $display("FAIL pid_active_in_packet: got %b want 1", active_before_eop); end
    checks++;
    if (rx_if.rx_active !== 1'b0) begin errors++; $display("FAIL pid_active_after_eop: got %b want 0", rx_if.rx_active); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL pid_pending: got %0d bytes left want 0", exp_q.size()); end
  endtask

  task automatic test_stuffing();
    int v0 = valid_cnt, e0 = err_cnt, n0 = valid_cyc.size();
    @(negedge clk);
    add_byte(8'hFF);
    add_byte(8'h3F);
    build(1'b1, 1'b1);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3F);
    send(BIT_NS, 0, sym_q.size());
    idle(4, BIT_NS);
    checks++;
    if (valid_cnt - v0 != 2) begin errors++; $display("FAIL stuff_valid_count: got %0d want 2", valid_cnt - v0); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL stuff_error_count: got %0d want 0", err_cnt - e0); end
    // 0x3F follows after 8 data bits plus one stuffed bit: 9 bit times.
    checks++;
    if (valid_cyc.size() < n0 + 2) begin
      errors++;
      $display("FAIL stuff_spacing: got %0d pulses want 2", valid_cyc.size() - n0);
    end else if (valid_cyc[n0 + 1] - valid_cyc[n0] != 144) begin
      errors++;
      $display("FAIL stuff_spacing: got %0d clk want 144", valid_cyc[n0 + 1] - valid_cyc[n0]);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stuff_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stuff_error();
    int v0 = valid_cnt, e0 = err_cnt;
    @(negedge clk);
    for (int i = 0; i < 7; i++) bits_q.push_back(1'b1);
    build(1'b0, 1'b0);
    send(BIT_NS, 0, 14);
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL stuff_err_early: got %0d want 0", err_cnt - e0); end
    send(BIT_NS, 14, 15);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL stuff_err_pulse: got %0d want 1", err_cnt - e0); end
    checks++;
    if (rx_if.rx_active !== 1'b0) begin errors++; $display("FAIL stuff_err_active: got %b want 0", rx_if.rx_active); end
    // Only 3 J bits of idle: the next packet must be ignored.
    idle(3, BIT_NS);
    add_byte(8'h2D);
    build(1'b1, 1'b1);
    send(BIT_NS, 0, sym_q.size());
    idle(10, BIT_NS);
    checks++;
    if (valid_cnt != v0) begin errors++; $display("FAIL short_idle_ignored: got %0d want 0", valid_cnt - v0); end
    add_byte(8'hA5);
    build(1'b1, 1'b1);
    exp_q.push_back(8'hA5);
    send(BIT_NS, 0, sym_q.size());
    idle(4, BIT_NS);
    checks++;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL after_idle_valid: got %0d want 1", valid_cnt - v0); end
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL after_idle_errors: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_partial_byte();
    int v0 = valid_cnt, e0 = err_cnt;
    @(negedge clk);
    add_byte(8'h2D);
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b1);
    build(1'b1, 1'b1);
    exp_q.push_back(8'h2D);
    send(BIT_NS, 0, sym_q.size());
    idle(4, BIT_NS);
    checks++;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL partial_valid: got %0d want 1", valid_cnt - v0); end
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("FAIL partial_error: got %0d want 1", err_cnt - e0); end
    checks++;
    if (rx_if.rx_active !== 1'b0) begin errors++; $display("FAIL partial_active: got %b want 0", rx_if.rx_active); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL partial_pending: got %0d want 0", exp_q.size()); end
    idle(10, BIT_NS);
  endtask

  task automatic test_drift(input real per);
    int v0 = valid_cnt, e0 = err_cnt;
    @(negedge clk);
    for (int b = 0; b < 32; b++) begin
      add_byte(8'(b));
      exp_q.push_back(8'(b));
    end
    build(1'b1, 1'b1);
    send(per, 0, sym_q.size());
    idle(10, per);
    checks++;
    if (valid_cnt - v0 != 32) begin errors++; $display("FAIL drift_valid_count: period %0.2f got %0d want 32", per, valid_cnt - v0); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL drift_errors: period %0.2f got %0d want 0", per, err_cnt - e0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drift_pending: got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midbyte();
    int v0, e0;
    @(negedge clk);
    add_byte(8'h2D);
    build(1'b1, 1'b1);
    send(BIT_NS, 0, 12);
    checks++;
    if (rx_if.rx_active !== 1'b1) begin errors++; $display("FAIL midbyte_active: got %b want 1", rx_if.rx_active); end
    reset = 1'b0;
    #1;
    checks++;
    if (rx_if.rx_active !== 1'b0) begin errors++; $display("FAIL async_reset_active: got %b want 0", rx_if.rx_active); end
    checks++;
    if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h want 00", rx_if.rx_data); end
    checks++;
    if (rx_if.rx_valid !== 1'b0 || rx_if.rx_error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_pulses: valid=%b error=%b want 0 0", rx_if.rx_valid, rx_if.rx_error);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    v0 = valid_cnt;
    e0 = err_cnt;
    idle(3, BIT_NS);
    add_byte(8'h2D);
    build(1'b1, 1'b1);
    send(BIT_NS, 0, sym_q.size());
    idle(10, BIT_NS);
    checks++;
    if (valid_cnt != v0) begin errors++; $display("FAIL post_reset_ignored: got %0d want 0", valid_cnt - v0); end
    add_byte(8'h2D);
    build(1'b1, 1'b1);
    exp_q.push_back(8'h2D);
    send(BIT_NS, 0, sym_q.size());
    idle(4, BIT_NS);
    checks++;
    if (valid_cnt - v0 != 1) begin errors++; $display("FAIL post_reset_valid: got %0d want 1", valid_cnt - v0); end
    checks++;
    if (err_cnt != e0) begin errors++; $display("FAIL post_reset_errors: got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_setup_pid();
    test_stuffing();
    test_stuff_error();
    test_partial_byte();
    test_drift(661.92);
    test_drift(682.08);
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
